// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared op encodings, state enum and default width for the EX mult/div unit
package muldiv_pkg;

  localparam int MD_DATA_W = 32;

  localparam logic [3:0] MD_NONE  = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MFHI  = 4'd5;
  localparam logic [3:0] MD_MFLO  = 4'd6;
  localparam logic [3:0] MD_MTHI  = 4'd7;
  localparam logic [3:0] MD_MTLO  = 4'd8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } md_state_t;

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// rtl/ex_muldiv_unit_if.sv - ID/EX-side op/operand bundle and hazard/result returns of the mult/div unit
interface ex_muldiv_unit_if #(
  parameter int DATA_W = 32
);
  logic [3:0]        MdOpE;
  logic [DATA_W-1:0] SrcAE;
  logic [DATA_W-1:0] SrcBE;
  logic              FlushE;
  logic              StallMdE;
  logic              BusyE;
  logic [DATA_W-1:0] MdResultE;
  logic [DATA_W-1:0] HiOut;
  logic [DATA_W-1:0] LoOut;

  modport master (
    output MdOpE, SrcAE, SrcBE, FlushE,
    input  StallMdE, BusyE, MdResultE, HiOut, LoOut
  );

  modport slave (
    input  MdOpE, SrcAE, SrcBE, FlushE,
    output StallMdE, BusyE, MdResultE, HiOut, LoOut
  );
endinterface

// File: rtl/muldiv_iter_core.sv
// rtl/muldiv_iter_core.sv - unsigned iterative engine: shift-add multiply or restoring divide, one bit per clock
module muldiv_iter_core
  import muldiv_pkg::*;
#(
  parameter int DATA_W = MD_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_start,
  input  logic              i_is_div,
  input  logic [DATA_W-1:0] i_op_a,
  input  logic [DATA_W-1:0] i_op_b,
  output logic              o_busy,
  output logic              o_done,
  output logic [DATA_W-1:0] o_hi,
  output logic [DATA_W-1:0] o_lo
);
  localparam int CW = $clog2(DATA_W);

  md_state_t         r_state, w_state_nxt;
  logic [CW-1:0]     r_count;
  logic              r_is_div;
  logic [DATA_W-1:0] r_hi, r_lo, r_b;
  logic [DATA_W-1:0] w_hi_nxt, w_lo_nxt;
  logic [DATA_W:0]   w_sum, w_shift, w_diff;

  // hi/lo hold partial product (mul) or remainder/quotient-with-dividend-shifting-out (div)
  always_comb begin
    w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
    w_shift = {r_hi, r_lo[DATA_W-1]};
    w_diff  = w_shift - {1'b0, r_b};
    if (!r_is_div) begin
      w_hi_nxt = w_sum[DATA_W:1];
      w_lo_nxt = {w_sum[0], r_lo[DATA_W-1:1]};
    end else if (!w_diff[DATA_W]) begin
      w_hi_nxt = w_diff[DATA_W-1:0];
      w_lo_nxt = {r_lo[DATA_W-2:0], 1'b1};
    end else begin
      w_hi_nxt = w_shift[DATA_W-1:0];
      w_lo_nxt = {r_lo[DATA_W-2:0], 1'b0};
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    o_busy      = (r_state != IDLE);
    o_done      = (r_state == FIX);
    case (r_state)
      IDLE:    if (i_start) w_state_nxt = RUN;
      RUN:     if (r_count == CW'(DATA_W - 1)) w_state_nxt = FIX;
      FIX:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_count  <= '0;
      r_is_div <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_b      <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == IDLE && i_start) begin
        r_count  <= '0;
        r_is_div <= i_is_div;
        r_hi     <= '0;
        r_lo     <= i_op_a;
        r_b      <= i_op_b;
      end else if (r_state == RUN) begin
        r_count <= r_count + 1'b1;
        r_hi    <= w_hi_nxt;
        r_lo    <= w_lo_nxt;
      end
    end
  end

  assign o_hi = r_hi;
  assign o_lo = r_lo;
endmodule

// File: rtl/ex_muldiv_unit.sv
// rtl/ex_muldiv_unit.sv - EX-stage MIPS HI/LO unit with stall request; MULDIV_FAST_MUL_EN selects single-cycle multiply
module ex_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int DATA_W = MD_DATA_W
) (
  input  logic            clk,
  input  logic            reset,
  ex_muldiv_unit_if.slave md
);
  logic [DATA_W-1:0]   r_hi, r_lo;
  logic                r_neg_q, r_neg_r, r_div0, r_is_div;
  logic                w_busy, w_done, w_is_md, w_is_mul, w_is_div, w_signed;
  logic                w_stall, w_accept, w_start;
  logic [DATA_W-1:0]   w_abs_a, w_abs_b, w_core_hi, w_core_lo;
  logic [2*DATA_W-1:0] w_prod, w_prod_fix;
  logic [DATA_W-1:0]   w_quo_fix, w_rem_fix;

  assign w_is_md  = (md.MdOpE >= MD_MULT) && (md.MdOpE <= MD_MTLO);
  assign w_is_mul = (md.MdOpE == MD_MULT) || (md.MdOpE == MD_MULTU);
  assign w_is_div = (md.MdOpE == MD_DIV)  || (md.MdOpE == MD_DIVU);
  assign w_signed = (md.MdOpE == MD_MULT) || (md.MdOpE == MD_DIV);
  assign w_abs_a  = (w_signed && md.SrcAE[DATA_W-1]) ? -md.SrcAE : md.SrcAE;
  assign w_abs_b  = (w_signed && md.SrcBE[DATA_W-1]) ? -md.SrcBE : md.SrcBE;

  // busy covers RUN and FIX, so any HI/LO consumer is held until the write lands
  assign w_stall  = w_busy && w_is_md && !md.FlushE;
  assign w_accept = w_is_md && !md.FlushE && !w_stall;
`ifdef MULDIV_FAST_MUL_EN
  assign w_start  = w_accept && w_is_div;
`else
  assign w_start  = w_accept && (w_is_mul || w_is_div);
`endif

  muldiv_iter_core #(.DATA_W(DATA_W)) u_core (
    .clk      (clk),
    .reset    (reset),
    .i_start  (w_start),
    .i_is_div (w_is_div),
    .i_op_a   (w_abs_a),
    .i_op_b   (w_abs_b),
    .o_busy   (w_busy),
    .o_done   (w_done),
    .o_hi     (w_core_hi),
    .o_lo     (w_core_lo)
  );

  // divide-by-zero forces LO to all-ones; HI naturally ends up as the dividend
  always_comb begin
    w_prod     = {w_core_hi, w_core_lo};
    w_prod_fix = r_neg_q ? -w_prod : w_prod;
    w_quo_fix  = r_div0 ? '1 : (r_neg_q ? -w_core_lo : w_core_lo);
    w_rem_fix  = r_neg_r ? -w_core_hi : w_core_hi;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hi     <= '0;
      r_lo     <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_div0   <= 1'b0;
      r_is_div <= 1'b0;
    end else begin
      if (w_start) begin
        r_neg_q  <= w_signed && (md.SrcAE[DATA_W-1] ^ md.SrcBE[DATA_W-1]);
        r_neg_r  <= w_signed && md.SrcAE[DATA_W-1];
        r_div0   <= (md.SrcBE == '0);
        r_is_div <= w_is_div;
      end
      if (w_done) begin
        if (r_is_div) begin
          r_hi <= w_rem_fix;
          r_lo <= w_quo_fix;
        end else begin
          {r_hi, r_lo} <= w_prod_fix;
        end
      end
      if (w_accept && md.MdOpE == MD_MTHI) r_hi <= md.SrcAE;
      if (w_accept && md.MdOpE == MD_MTLO) r_lo <= md.SrcAE;
`ifdef MULDIV_FAST_MUL_EN
      if (w_accept && w_is_mul) begin
        if (w_signed && (md.SrcAE[DATA_W-1] ^ md.SrcBE[DATA_W-1]))
          {r_hi, r_lo} <= -({{DATA_W{1'b0}}, w_abs_a} * {{DATA_W{1'b0}}, w_abs_b});
        else
          {r_hi, r_lo} <= {{DATA_W{1'b0}}, w_abs_a} * {{DATA_W{1'b0}}, w_abs_b};
      end
`endif
    end
  end

  always_comb begin
    md.MdResultE = '0;
    if (!w_busy && md.MdOpE == MD_MFHI) md.MdResultE = r_hi;
    if (!w_busy && md.MdOpE == MD_MFLO) md.MdResultE = r_lo;
  end

  assign md.StallMdE = w_stall;
  assign md.BusyE    = w_busy;
  assign md.HiOut    = r_hi;
  assign md.LoOut    = r_lo;
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb/tb_ex_muldiv_unit.sv - directed self-checking bench for ex_muldiv_unit (default iterative build)
module tb_ex_muldiv_unit;
  import muldiv_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   n;

  ex_muldiv_unit_if #(.DATA_W(32)) md_if ();

  ex_muldiv_unit #(.DATA_W(32)) u_dut (
    .clk   (clk),
    .reset (reset),
    .md    (md_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic fl);
    md_if.MdOpE  = op;
    md_if.SrcAE  = a;
    md_if.SrcBE  = b;
    md_if.FlushE = fl;
  endtask

  task automatic run_md(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, output int busy_n);
    drive(op, a, b, 1'b0);
    @(posedge clk); #2;
    drive(MD_NONE, 0, 0, 1'b0);
    #1;
    busy_n = 0;
    while (md_if.BusyE && busy_n < 100) begin
      busy_n++;
      @(posedge clk); #3;
    end
  endtask

  initial begin
    reset = 1'b1;
    drive(MD_NONE, 0, 0, 1'b0);
    repeat (2) @(posedge clk);
    #3;
    check("rst_busy",   md_if.BusyE,     32'd0);
    check("rst_stall",  md_if.StallMdE,  32'd0);
    check("rst_result", md_if.MdResultE, 32'd0);
    check("rst_hi",     md_if.HiOut,     32'd0);
    check("rst_lo",     md_if.LoOut,     32'd0);
    @(posedge clk); #2;
    reset = 1'b0;

    // MULT -2 * 3 followed immediately by MFLO
    drive(MD_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0);
    #1;
    check("mult_issue_stall", md_if.StallMdE, 32'd0);
    @(posedge clk); #2;
    drive(MD_MFLO, 0, 0, 1'b0);
    #1;
    check("mult_busy", md_if.BusyE, 32'd1);
    n = 0;
    while (md_if.StallMdE && n < 100) begin
      n++;
      @(posedge clk); #3;
    end
    check("mflo_stall_cycles", n,               32'd33);
    check("mult_mflo",         md_if.MdResultE, 32'hFFFF_FFFA);
    check("mult_hi",           md_if.HiOut,     32'hFFFF_FFFF);
    check("mult_lo",           md_if.LoOut,     32'hFFFF_FFFA);
    check("mult_idle",         md_if.BusyE,     32'd0);
    drive(MD_NONE, 0, 0, 1'b0);

    run_md(MD_DIVU, 32'd100, 32'd7, n);
    check("divu_busy_cycles", n, 32'd33);
    check("divu_lo", md_if.LoOut, 32'd14);
    check("divu_hi", md_if.HiOut, 32'd2);

    run_md(MD_DIV, 32'hFFFF_FFF9, 32'd2, n);
    check("div_neg_lo", md_if.LoOut, 32'hFFFF_FFFD);
    check("div_neg_hi", md_if.HiOut, 32'hFFFF_FFFF);

    run_md(MD_DIV, 32'd5, 32'd0, n);
    check("div0_busy_cycles", n, 32'd33);
    check("div0_hi", md_if.HiOut, 32'd5);
    check("div0_lo", md_if.LoOut, 32'hFFFF_FFFF);

    run_md(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, n);
    check("div_ovf_lo", md_if.LoOut, 32'h8000_0000);
    check("div_ovf_hi", md_if.HiOut, 32'd0);

    run_md(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, n);
    check("multu_max_hi", md_if.HiOut, 32'hFFFF_FFFE);
    check("multu_max_lo", md_if.LoOut, 32'h0000_0001);

    run_md(MD_MULT, 32'h8000_0000, 32'h8000_0000, n);
    check("mult_min_hi", md_if.HiOut, 32'h4000_0000);
    check("mult_min_lo", md_if.LoOut, 32'h0000_0000);

    // MTHI then MFHI back-to-back while idle
    drive(MD_MTHI, 32'h0000_1234, 0, 1'b0);
    #1;
    check("mthi_stall", md_if.StallMdE, 32'd0);
    @(posedge clk); #2;
    drive(MD_MFHI, 0, 0, 1'b0);
    #1;
    check("mfhi_stall",  md_if.StallMdE,  32'd0);
    check("mfhi_result", md_if.MdResultE, 32'h0000_1234);
    @(posedge clk); #2;

    // MULTU 0x10000 * 0x10000 with flushed MFLO and out-of-range ops during RUN
    drive(MD_MULTU, 32'h0001_0000, 32'h0001_0000, 1'b0);
    @(posedge clk); #2;
    drive(MD_MFLO, 0, 0, 1'b1);
    #1;
    check("flush_busy",  md_if.BusyE,    32'd1);
    check("flush_stall", md_if.StallMdE, 32'd0);
    @(posedge clk); #2;
    drive(MD_MFLO, 0, 0, 1'b0);
    #1;
    check("busy_mflo_stall", md_if.StallMdE, 32'd1);
    @(posedge clk); #2;
    drive(4'd9, 0, 0, 1'b0);
    #1;
    check("op9_stall", md_if.StallMdE, 32'd0);
    @(posedge clk); #2;
    drive(4'd15, 0, 0, 1'b0);
    #1;
    check("op15_stall", md_if.StallMdE, 32'd0);
    drive(MD_NONE, 0, 0, 1'b0);
    n = 0;
    while (md_if.BusyE && n < 100) begin
      n++;
      @(posedge clk); #3;
    end
    check("flush_run_done", md_if.BusyE, 32'd0);
    check("flush_mul_hi",   md_if.HiOut, 32'd1);
    check("flush_mul_lo",   md_if.LoOut, 32'd0);

    drive(MD_MTLO, 32'h0000_ABCD, 0, 1'b0);
    @(posedge clk); #2;
    drive(MD_NONE, 0, 0, 1'b0);
    #1;
    check("mtlo_lo", md_if.LoOut, 32'h0000_ABCD);

    // reset in the middle of RUN (count 10)
    drive(MD_MULT, 32'd7, 32'd9, 1'b0);
    @(posedge clk); #2;
    drive(MD_NONE, 0, 0, 1'b0);
    repeat (10) @(posedge clk);
    #2;
    check("pre_reset_busy", md_if.BusyE, 32'd1);
    reset = 1'b1;
    @(posedge clk); #2;
    reset = 1'b0;
    drive(MD_MFLO, 0, 0, 1'b0);
    #1;
    check("abort_busy",   md_if.BusyE,     32'd0);
    check("abort_hi",     md_if.HiOut,     32'd0);
    check("abort_lo",     md_if.LoOut,     32'd0);
    check("abort_stall",  md_if.StallMdE,  32'd0);
    check("abort_result", md_if.MdResultE, 32'd0);
    @(posedge clk); #2;
    drive(MD_NONE, 0, 0, 1'b0);
    #1;
    check("abort_stays_idle", md_if.BusyE, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
